// File: rtl/game_video_pkg.sv
// -----------------------------------------------------------------------------
// game_video_pkg
// Shared constants and types for the game video path.
//   RGB_W_DEF  : default packed colour width (3 equal channels)
//   CH_W_DEF   : default channel width
//   FADE_MAX   : fade level meaning full brightness (identity)
//   BLACK/WHITE: 12-bit colour constants
//   fade_state_e : brightness ramp FSM states
// -----------------------------------------------------------------------------
package game_video_pkg;

    localparam int RGB_W_DEF = 12;
    localparam int CH_W_DEF  = RGB_W_DEF / 3;
    localparam int FADE_MAX  = 16;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_DOWN = 2'd1,
        FADE_UP   = 2'd2
    } fade_state_e;

endpackage

// File: rtl/layer_priority_sel.sv
// -----------------------------------------------------------------------------
// layer_priority_sel
// Combinational priority picker: lowest-index layer that is both hit and
// enabled wins. Reusable by any overlay stack.
//   layer_on_i  : per-layer pixel-hit flags
//   layer_en_i  : per-layer enables
//   layer_rgb_i : layer i colour at [RGB_W*i +: RGB_W]
//   hit_o       : some enabled layer is hit
//   sel_rgb_o   : colour of the winning layer (0 when no hit)
// -----------------------------------------------------------------------------
module layer_priority_sel #(
    parameter int N_LAYERS = 10,
    parameter int RGB_W    = 12
) (
    input  logic [N_LAYERS-1:0]       layer_on_i,
    input  logic [N_LAYERS-1:0]       layer_en_i,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb_i,
    output logic                      hit_o,
    output logic [RGB_W-1:0]          sel_rgb_o
);

    // Scan from the lowest priority upward so the last assignment made is
    // the highest-priority (lowest-index) active layer.
    always_comb begin
        hit_o     = 1'b0;
        sel_rgb_o = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_on_i[i] && layer_en_i[i]) begin
                hit_o     = 1'b1;
                sel_rgb_o = layer_rgb_i[RGB_W*i +: RGB_W];
            end
        end
    end

endmodule

// File: rtl/rgb_layer_mixer.sv
// -----------------------------------------------------------------------------
// rgb_layer_mixer
// Two-stage pixel_tick pipeline compositing N_LAYERS layers over a
// background, with a frame-latched layer mask, an invert-flash effect and an
// optional brightness fade (build with RGB_MIXER_FADE_EN defined).
//   clk, reset_n        : clock, asynchronous active-low reset
//   pixel_tick          : pipeline advance enable
//   video_on            : active video for the current pixel
//   frame_start         : once-per-frame pulse (vertical blanking)
//   layer_on/layer_rgb  : per-layer hit flags and colours
//   bg_rgb              : background colour
//   layer_mask_next     : layer enables, latched at frame_start
//   flash_req           : start/restart invert flash
//   fade_in / fade_out  : brightness ramp requests (ignored without fade)
//   rgb                 : registered output colour
//   flash_active        : flash counter nonzero
//   fade_busy           : fade ramp in progress (0 without fade)
// -----------------------------------------------------------------------------
module rgb_layer_mixer
    import game_video_pkg::*;
#(
    parameter int N_LAYERS         = 10,
    parameter int RGB_W            = RGB_W_DEF,
    parameter int FLASH_FRAMES     = 8,
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pixel_tick,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic [N_LAYERS-1:0]       layer_mask_next,
    input  logic                      flash_req,
    input  logic                      fade_in,
    input  logic                      fade_out,
    output logic [RGB_W-1:0]          rgb,
    output logic                      flash_active,
    output logic                      fade_busy
);

    localparam int CH_W = RGB_W / 3;
    localparam int FL_W = $clog2(FLASH_FRAMES + 1);

    logic [N_LAYERS-1:0] mask_q;
    logic [RGB_W-1:0]    sel_rgb_q;
    logic                vid1_q;
    logic [RGB_W-1:0]    rgb_q;
    logic [FL_W-1:0]     flash_cnt_q, flash_cnt_d;

    logic                hit;
    logic [RGB_W-1:0]    pick_rgb;
    logic [RGB_W-1:0]    flash_rgb;
    logic [RGB_W-1:0]    scaled_rgb;

    layer_priority_sel #(
        .N_LAYERS (N_LAYERS),
        .RGB_W    (RGB_W)
    ) u_sel (
        .layer_on_i  (layer_on),
        .layer_en_i  (mask_q),
        .layer_rgb_i (layer_rgb),
        .hit_o       (hit),
        .sel_rgb_o   (pick_rgb)
    );

    // Pipeline and mask. The mask register is read by stage 1 before its
    // own update, so a tick coinciding with frame_start sees the old mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '1;
            sel_rgb_q <= '0;
            vid1_q    <= 1'b0;
            rgb_q     <= '0;
        end else begin
            if (frame_start) begin
                mask_q <= layer_mask_next;
            end
            if (pixel_tick) begin
                sel_rgb_q <= hit ? pick_rgb : bg_rgb;
                vid1_q    <= video_on;
                rgb_q     <= vid1_q ? scaled_rgb : '0;
            end
        end
    end

    // Flash counter: a request always (re)loads, even on a frame_start cycle.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flash_req) begin
            flash_cnt_d = FL_W'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt_q <= '0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // Odd counts invert; bit 0 set already implies the counter is nonzero.
    assign flash_rgb = flash_cnt_q[0] ? ~sel_rgb_q : sel_rgb_q;

`ifdef RGB_MIXER_FADE_EN
    localparam int STEP_W = $clog2(FADE_STEP_FRAMES + 1);

    fade_state_e         state_q, state_d;
    logic [4:0]          level_q, level_d;
    logic [STEP_W-1:0]   step_q, step_d;

    // A new request restarts the step counter but keeps the current level,
    // so a reversal mid-ramp continues smoothly from where it was.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        if (fade_in) begin
            state_d = FADE_UP;
            step_d  = '0;
        end else if (fade_out) begin
            state_d = FADE_DOWN;
            step_d  = '0;
        end else begin
            case (state_q)
                FADE_DOWN: begin
                    if (level_q == 5'd0) begin
                        state_d = FADE_IDLE;
                    end else if (frame_start) begin
                        if (step_q == STEP_W'(FADE_STEP_FRAMES - 1)) begin
                            step_d  = '0;
                            level_d = level_q - 5'd1;
                            if (level_q == 5'd1) state_d = FADE_IDLE;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                FADE_UP: begin
                    if (level_q == 5'(FADE_MAX)) begin
                        state_d = FADE_IDLE;
                    end else if (frame_start) begin
                        if (step_q == STEP_W'(FADE_STEP_FRAMES - 1)) begin
                            step_d  = '0;
                            level_d = level_q + 5'd1;
                            if (level_q == 5'(FADE_MAX - 1)) state_d = FADE_IDLE;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FADE_IDLE;
            level_q <= 5'(FADE_MAX);
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    // Per-channel (ch * level) >> 4; level 16 returns ch unchanged.
    for (genvar gi = 0; gi < 3; gi++) begin : g_scale
        logic [CH_W+4:0] prod;
        assign prod = (CH_W+5)'(flash_rgb[gi*CH_W +: CH_W]) * (CH_W+5)'(level_q);
        assign scaled_rgb[gi*CH_W +: CH_W] = prod[CH_W+3:4];
    end

    assign fade_busy = (state_q != FADE_IDLE);
`else
    logic unused_fade_req;
    assign unused_fade_req = fade_in ^ fade_out;
    assign scaled_rgb      = flash_rgb;
    assign fade_busy       = 1'b0;
`endif

    assign rgb          = rgb_q;
    assign flash_active = (flash_cnt_q != '0);

endmodule

// File: tb/tb_rgb_layer_mixer.sv
// -----------------------------------------------------------------------------
// tb_rgb_layer_mixer
// Directed scenarios followed by random traffic, all compared each cycle
// against a behavioural model of the mixer. Define RGB_MIXER_FADE_EN to
// include the fade scenarios and fade modelling.
// -----------------------------------------------------------------------------
module tb_rgb_layer_mixer;

    localparam int N  = 10;
    localparam int W  = 12;
    localparam int FF = 8;
    localparam int FS = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            pixel_tick = 1'b0;
    logic            video_on = 1'b0;
    logic            frame_start = 1'b0;
    logic [N-1:0]    layer_on = '0;
    logic [N*W-1:0]  layer_rgb;
    logic [W-1:0]    bg_rgb = '0;
    logic [N-1:0]    layer_mask_next = '1;
    logic            flash_req = 1'b0;
    logic            fade_in = 1'b0;
    logic            fade_out = 1'b0;
    logic [W-1:0]    rgb;
    logic            flash_active;
    logic            fade_busy;

    logic [W-1:0]    lrgb [N];

    int total = 0;
    int bad   = 0;

    // Model state (plain integers / arrays).
    logic [N-1:0] m_mask;
    int           m_s1, m_vid, m_rgb, m_flash, m_level, m_step;
    int           m_dir;   // 0 idle, -1 ramping down, +1 ramping up

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) layer_rgb[W*i +: W] = lrgb[i];
    end

    rgb_layer_mixer #(
        .N_LAYERS         (N),
        .RGB_W            (W),
        .FLASH_FRAMES     (FF),
        .FADE_STEP_FRAMES (FS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pixel_tick      (pixel_tick),
        .video_on        (video_on),
        .frame_start     (frame_start),
        .layer_on        (layer_on),
        .layer_rgb       (layer_rgb),
        .bg_rgb          (bg_rgb),
        .layer_mask_next (layer_mask_next),
        .flash_req       (flash_req),
        .fade_in         (fade_in),
        .fade_out        (fade_out),
        .rgb             (rgb),
        .flash_active    (flash_active),
        .fade_busy       (fade_busy)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask  = '1;
        m_s1    = 0;
        m_vid   = 0;
        m_rgb   = 0;
        m_flash = 0;
        m_level = 16;
        m_step  = 0;
        m_dir   = 0;
    endtask

    function automatic int pick();
        for (int i = 0; i < N; i++)
            if (layer_on[i] && m_mask[i]) return int'(lrgb[i]);
        return int'(bg_rgb);
    endfunction

    function automatic int shade(input int c, input int lvl);
        int r = 0;
        for (int k = 0; k < 3; k++)
            r += (((c >> (4*k)) & 15) * lvl / 16) << (4*k);
        return r;
    endfunction

    // One clock of the reference behaviour, from the inputs present at the edge.
    task automatic model_update();
        int c;
        if (pixel_tick) begin
            c = m_s1;
            if (m_flash % 2 == 1) c = c ^ 12'hFFF;
`ifdef RGB_MIXER_FADE_EN
            c = shade(c, m_level);
`endif
            m_rgb = m_vid ? c : 0;
            m_s1  = pick();
            m_vid = int'(video_on);
        end
        if (flash_req) m_flash = FF;
        else if (frame_start && m_flash > 0) m_flash--;
`ifdef RGB_MIXER_FADE_EN
        if (fade_in) begin
            m_dir = 1; m_step = 0;
        end else if (fade_out) begin
            m_dir = -1; m_step = 0;
        end else if (m_dir != 0) begin
            if ((m_dir > 0 && m_level == 16) || (m_dir < 0 && m_level == 0)) begin
                m_dir = 0;
            end else if (frame_start) begin
                m_step++;
                if (m_step == FS) begin
                    m_step  = 0;
                    m_level += m_dir;
                    if (m_level == 0 || m_level == 16) m_dir = 0;
                end
            end
        end
`endif
        if (frame_start) m_mask = layer_mask_next;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_update();
        #1;
        check_val("rgb", int'(rgb), m_rgb);
        check_val("flash_active", int'(flash_active), int'(m_flash != 0));
        check_val("fade_busy", int'(fade_busy), int'(m_dir != 0));
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) lrgb[i] = W'(i * 12'h111);
        model_reset();
        repeat (3) step();
        #2 reset_n = 1'b1;
        check_val("reset_rgb", int'(rgb), 0);
        check_val("reset_flash", int'(flash_active), 0);
        check_val("reset_busy", int'(fade_busy), 0);

        // Priority
        pixel_tick = 1'b1; video_on = 1'b1;
        lrgb[1] = 12'h0F0; lrgb[2] = 12'hF00; bg_rgb = 12'h123;
        layer_on = 10'b0000000110;
        step(); step();
        check_val("prio_l1", int'(rgb), 12'h0F0);
        $display("txn prio layer_on=%b rgb=%h", layer_on, rgb);
        layer_on = '0;
        step(); step();
        check_val("prio_bg", int'(rgb), 12'h123);
        $display("txn bg rgb=%h", rgb);

        // Mask timing
        layer_on = 10'b0000000110;
        layer_mask_next = 10'b1111111101;
        step(); step();
        check_val("mask_old", int'(rgb), 12'h0F0);
        frame_pulse();
        step(); step();
        check_val("mask_new", int'(rgb), 12'hF00);
        $display("txn mask rgb=%h", rgb);
        layer_mask_next = '1;
        frame_pulse();
        step(); step();

        // Blanking and stall
        video_on = 1'b0;
        step(); step();
        check_val("blank", int'(rgb), 0);
        video_on = 1'b1;
        step(); step();
        pixel_tick = 1'b0;
        layer_on = '0;
        repeat (5) step();
        check_val("stall_hold", int'(rgb), 12'h0F0);
        $display("txn stall rgb=%h", rgb);
        pixel_tick = 1'b1;
        layer_on = 10'b0000000110;
        step(); step();

        // Flash
        flash_req = 1'b1; step(); flash_req = 1'b0;
        step(); step();
        check_val("flash_start", int'(rgb), 12'h0F0);
        for (int k = 1; k <= FF; k++) begin
            frame_pulse();
            step(); step();
            check_val("flash_rgb", int'(rgb), ((FF - k) % 2 == 1) ? 12'hF0F : 12'h0F0);
            check_val("flash_act", int'(flash_active), int'(k < FF));
            $display("txn flash frame=%0d rgb=%h active=%0d", k, rgb, flash_active);
        end
        flash_req = 1'b1; frame_start = 1'b1;
        step();
        flash_req = 1'b0; frame_start = 1'b0;
        step(); step();
        check_val("flash_load_wins", int'(rgb), 12'h0F0);

`ifdef RGB_MIXER_FADE_EN
        lrgb[0] = 12'hFFF; layer_on = 10'b1;
        fade_out = 1'b1; step(); fade_out = 1'b0;
        repeat (32) begin frame_pulse(); step(); end
        step(); step();
        check_val("fade_black", int'(rgb), 0);
        check_val("fade_out_done", int'(fade_busy), 0);
        fade_in = 1'b1; step(); fade_in = 1'b0;
        repeat (16) begin frame_pulse(); step(); end
        step(); step();
        check_val("fade_half", int'(rgb), 12'h777);
        repeat (16) begin frame_pulse(); step(); end
        step(); step();
        check_val("fade_full", int'(rgb), 12'hFFF);
        check_val("fade_in_done", int'(fade_busy), 0);
        $display("txn fade rgb=%h", rgb);
`endif

        // Asynchronous reset mid-flash/fade
        flash_req = 1'b1; fade_out = 1'b1; step();
        flash_req = 1'b0; fade_out = 1'b0;
        step(); step();
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rgb", int'(rgb), 0);
        check_val("async_flash", int'(flash_active), 0);
        check_val("async_busy", int'(fade_busy), 0);
        model_reset();
        step(); step();
        #2 reset_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            pixel_tick      = ($urandom_range(0, 3) != 0);
            video_on        = ($urandom_range(0, 4) != 0);
            frame_start     = ($urandom_range(0, 24) == 0);
            layer_on        = N'($urandom);
            layer_mask_next = N'($urandom) | N'($urandom);
            bg_rgb          = W'($urandom);
            for (int i = 0; i < N; i++) lrgb[i] = W'($urandom);
            flash_req       = ($urandom_range(0, 59) == 0);
            fade_in         = ($urandom_range(0, 149) == 0);
            fade_out        = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_layer_mixer.md
Name: rgb_layer_mixer

Overview:
Parametrised replacement for the fixed if/else RGB priority chain in the display top. Composites N_LAYERS sprite/overlay layers over a background in a 2-stage pixel_tick pipeline. Per-layer enable mask updates only at frame boundaries, so a frame never mixes masks. Adds a frame-counted invert-flash effect (collision feedback) and, optionally, a brightness fade for state transitions.

Parameters:
N_LAYERS, 10, number of prioritised layers; index 0 is the highest priority.
RGB_W, 12, colour width: 3 channels of RGB_W/3 bits.
FLASH_FRAMES, 8, number of frames a flash lasts; must be ≥1.
FADE_STEP_FRAMES, 2, frames per fade step; must be ≥1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_tick  in  1  pixel enable; the pipeline advances only on it
video_on  in  1  active video for the current x/y
frame_start  in  1  one-cycle pulse, once per frame, inside vertical blanking
layer_on  in  N_LAYERS  per-layer pixel-hit flags
layer_rgb  in  N_LAYERS*RGB_W  layer i colour at [RGB_W*i +: RGB_W]
bg_rgb  in  RGB_W  background colour
layer_mask_next  in  N_LAYERS  requested layer enables, sampled at frame_start
flash_req  in  1  pulse: start or restart a flash
fade_in  in  1  pulse: ramp brightness up to full
fade_out  in  1  pulse: ramp brightness down to black
rgb  out  RGB_W  registered pixel colour to the VGA DAC
flash_active  out  1  flash counter is nonzero
fade_busy  out  1  fade ramp is in progress

Behaviour:
- Reset (reset_n low, asynchronous):
  - rgb=0, stage registers=0, mask_active=all ones.
  - flash_cnt=0, flash_active=0.
  - fade_level=16, fade_busy=0, fade state IDLE.
- Stage 1 (on pixel_tick):
  - sel = lowest i with layer_on[i] & mask_active[i]; if none, bg_rgb.
  - Register sel_rgb and vid1=video_on.
- Stage 2 (on pixel_tick):
  - c = sel_rgb.
  - If flash_cnt≠0 and flash_cnt[0]=1, c = ~c.
  - Apply fade to c.
  - rgb = vid1 ? c : 0.
- Latency: exactly 2 pixel_ticks from inputs to rgb. Without pixel_tick all pipeline registers hold.
- Mask: mask_active <= layer_mask_next on frame_start. A pixel_tick in the same cycle uses the old mask.
- Flash counter:
  - flash_req loads FLASH_FRAMES.
  - Otherwise frame_start decrements while nonzero and saturates at 0.
  - flash_req together with frame_start: the load wins, no decrement.
  - flash_req while active: reload.
  - flash_active = (flash_cnt≠0).
- Fade FSM (states IDLE, DOWN, UP):
  - fade_out → DOWN; fade_in → UP. If both pulse in the same cycle, fade_in wins. A new request mid-ramp redirects from the current level.
  - Frame counter counts frame_start. Every FADE_STEP_FRAMES frames, the level moves ±1.
  - DOWN reaching 0 → IDLE. UP reaching 16 → IDLE.
  - fade_busy = (state≠IDLE).
  - Per channel: out = (ch*fade_level)>>4. Multiply width is channel width+5 bits. Level 16 is identity; level 0 is black.
- Mid-operation reset clears everything immediately. The first valid rgb follows 2 pixel_ticks after release.

Optional Feature:
- RGB_MIXER_FADE_EN.
- Defined: fade FSM, level register and scaler are built as above.
- Undefined:
  - fade_in and fade_out are ignored.
  - fade_level is constant 16 (stage 2 passes colour through).
  - fade_busy is tied 0.
  - Port list is unchanged.

Decomposition:
- Package game_video_pkg:
  - RGB_W default.
  - Channel width.
  - FADE_MAX=16.
  - Colour constants BLACK=12'h000, WHITE=12'hFFF.
  - Fade state enum.
- Sub-module layer_priority_sel:
  - Combinational, parametrised N_LAYERS.
  - Outputs hit flag and selected RGB.
  - Reusable by the hearts and score overlays.

Test Plan:
- Priority: layer_on=0b0000000110, mask all ones, layer1=12'h0F0, layer2=12'hF00 → rgb=12'h0F0 two ticks later. layer_on=0 → bg_rgb.
- Mask timing: set layer_mask_next bit1=0 mid-frame → layer1 is still shown until frame_start. After frame_start → 12'hF00 (layer2).
- Blanking/stall: video_on=0 → rgb=0 after 2 ticks. Hold pixel_tick low for 5 cycles → rgb unchanged.
- Flash:
  - flash_req with FLASH_FRAMES=8, layer colour 12'h0F0 → no inversion (cnt=8) until the first frame_start. Then 12'hF0F on odd counts 7,5,3,1, normal on even counts. flash_active falls after 8 frames.
  - flash_req on a frame_start cycle → cnt=8, no decrement.
- Fade (RGB_MIXER_FADE_EN):
  - fade_out with FADE_STEP_FRAMES=2 → level 0 after 32 frames, rgb=0, fade_busy drops.
  - fade_in at level 8 → 12'hFFF displays as 12'h777 before ramping up; 12'hFFF at level 16.
- Reset: assert reset_n low mid-flash/fade → rgb=0, flash_active=0, fade_busy=0 within the same cycle (asynchronous).
